// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_pkg
//  Description : Shared definitions for the sequential ALU: the 16 opcode
//                encodings and the IDLE/BUSY state encoding used by the
//                handshake controller.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_seq_pkg;

    localparam logic [3:0] ALU_PASS_S = 4'b0000;
    localparam logic [3:0] ALU_PASS_R = 4'b0001;
    localparam logic [3:0] ALU_INC_S  = 4'b0010;
    localparam logic [3:0] ALU_DEC_S  = 4'b0011;
    localparam logic [3:0] ALU_ADD    = 4'b0100;
    localparam logic [3:0] ALU_SUB    = 4'b0101;
    localparam logic [3:0] ALU_SHR1   = 4'b0110;
    localparam logic [3:0] ALU_SHL1   = 4'b0111;
    localparam logic [3:0] ALU_AND    = 4'b1000;
    localparam logic [3:0] ALU_OR     = 4'b1001;
    localparam logic [3:0] ALU_XOR    = 4'b1010;
    localparam logic [3:0] ALU_NOT_S  = 4'b1011;
    localparam logic [3:0] ALU_NEG_S  = 4'b1100;
    localparam logic [3:0] ALU_MUL    = 4'b1101;
    localparam logic [3:0] ALU_SHL_N  = 4'b1110;
    localparam logic [3:0] ALU_SHR_N  = 4'b1111;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_seq_iter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_iter
//  Description : Iterative engine for multi-bit shifts (one bit per cycle)
//                and, when ALU_MUL_EN is defined, an unsigned shift-add
//                multiply (WIDTH cycles).
//  Ports       : clk, rst_n         clock, async active-low reset
//                start              load operands and begin iterating
//                op                 ALU_SHL_N / ALU_SHR_N / ALU_MUL
//                a                  shift source, or multiplicand
//                b                  multiplier (multiply only)
//                cnt                shift distance (must be non-zero)
//                done               high during the final step
//                result, carry      value/carry produced by the final step
//  Config      : ALU_MUL_EN enables the multiply datapath.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_seq_iter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    localparam int CW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [CW-1:0]    cnt,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    localparam logic [CW:0] C_ONE = (CW+1)'(1);

    logic             r_active;
    logic [CW:0]      r_cnt;
    logic             r_shl;
    logic [WIDTH-1:0] r_val;
    logic             w_last;
    logic [WIDTH-1:0] w_val_next;
    logic             w_shift_out;

`ifdef ALU_MUL_EN
    localparam logic [CW:0] C_MUL_STEPS = (CW+1)'(WIDTH);

    logic               r_mul;
    logic [WIDTH-1:0]   r_mcand;
    // Upper half accumulates partial sums, lower half holds the remaining
    // multiplier bits; both shift right together each step.
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH:0]     w_partial;
    logic [2*WIDTH-1:0] w_prod_next;
`else
    logic               w_unused_b;
    assign w_unused_b = ^b;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_shl    <= 1'b0;
            r_val    <= '0;
`ifdef ALU_MUL_EN
            r_mul    <= 1'b0;
            r_mcand  <= '0;
            r_prod   <= '0;
`endif
        end else if (start) begin
            r_active <= 1'b1;
            r_shl    <= (op == ALU_SHL_N);
            r_val    <= a;
            r_cnt    <= {1'b0, cnt};
`ifdef ALU_MUL_EN
            r_mul    <= (op == ALU_MUL);
            r_mcand  <= a;
            r_prod   <= {{WIDTH{1'b0}}, b};
            if (op == ALU_MUL) begin
                r_cnt <= C_MUL_STEPS;
            end
`endif
        end else if (r_active) begin
            r_cnt <= r_cnt - C_ONE;
            r_val <= w_val_next;
`ifdef ALU_MUL_EN
            r_prod <= w_prod_next;
`endif
            if (w_last) begin
                r_active <= 1'b0;
            end
        end
    end

    always_comb begin
        w_last      = (r_cnt == C_ONE);
        done        = r_active & w_last;
        w_val_next  = r_shl ? {r_val[WIDTH-2:0], 1'b0} : {1'b0, r_val[WIDTH-1:1]};
        w_shift_out = r_shl ? r_val[WIDTH-1] : r_val[0];
`ifdef ALU_MUL_EN
        w_partial   = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                    + (r_prod[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
        w_prod_next = {w_partial, r_prod[WIDTH-1:1]};
        result      = r_mul ? w_prod_next[WIDTH-1:0] : w_val_next;
        carry       = r_mul ? (|w_prod_next[2*WIDTH-1:WIDTH]) : w_shift_out;
`else
        result      = w_val_next;
        carry       = w_shift_out;
`endif
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Registered ALU with valid/ready handshakes. Single-cycle
//                ops load the output register at the accept edge; shifts by
//                k>0 (and multiply when ALU_MUL_EN is defined) run in the
//                iterative engine while the FSM sits in BUSY.
//  Ports       : clk, rst_n              clock, async active-low reset
//                in_valid/in_ready       operand handshake
//                alu_op, r, s            opcode and operands
//                out_valid/out_ready     result handshake
//                y, n, z, c              result and N/Z/C flags
//                busy                    high while an iterative op runs
//  Config      : ALU_MUL_EN makes opcode 1101 an iterative multiply;
//                otherwise 1101 passes S through in one cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             n,
    output logic             z,
    output logic             c,
    output logic             busy
);

    localparam int             CW    = $clog2(WIDTH);
    localparam logic [WIDTH:0] C_ONE = (WIDTH+1)'(1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_y;
    logic             r_c;
    logic             r_n;
    logic             r_z;
    logic             r_out_valid;

    logic             w_accept;
    logic             w_multi;
    logic             w_load;
    logic [WIDTH:0]   w_single;
    logic [WIDTH:0]   w_r_ext;
    logic [WIDTH:0]   w_s_ext;
    logic [WIDTH-1:0] w_res_y;
    logic             w_res_c;
    logic [CW-1:0]    w_shift_k;
    logic [WIDTH-1:0] w_iter_a;
    logic             w_iter_done;
    logic [WIDTH-1:0] w_iter_result;
    logic             w_iter_carry;

    assign in_ready  = (r_state == IDLE) & (~r_out_valid | out_ready);
    assign w_accept  = in_valid & in_ready;
    assign w_shift_k = r[CW-1:0];
    assign w_r_ext   = {1'b0, r};
    assign w_s_ext   = {1'b0, s};
    assign w_iter_a  = (alu_op == ALU_MUL) ? r : s;

    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign n         = r_n;
    assign z         = r_z;
    assign c         = r_c;
    assign busy      = (r_state == BUSY);

    // Which accepted ops go to the engine; a zero-distance shift is a plain pass.
    always_comb begin
        w_multi = 1'b0;
        case (alu_op)
            ALU_SHL_N,
            ALU_SHR_N: w_multi = (w_shift_k != '0);
`ifdef ALU_MUL_EN
            ALU_MUL:   w_multi = 1'b1;
`endif
            default:   w_multi = 1'b0;
        endcase
    end

    // {carry, value} for every single-cycle op; bit WIDTH is the carry/borrow.
    always_comb begin
        w_single = w_s_ext;
        case (alu_op)
            ALU_PASS_R: w_single = w_r_ext;
            ALU_INC_S:  w_single = w_s_ext + C_ONE;
            ALU_DEC_S:  w_single = w_s_ext - C_ONE;
            ALU_ADD:    w_single = w_r_ext + w_s_ext;
            ALU_SUB:    w_single = w_r_ext - w_s_ext;
            ALU_SHR1:   w_single = {s[0], 1'b0, s[WIDTH-1:1]};
            ALU_SHL1:   w_single = {s, 1'b0};
            ALU_AND:    w_single = {1'b0, r & s};
            ALU_OR:     w_single = {1'b0, r | s};
            ALU_XOR:    w_single = {1'b0, r ^ s};
            ALU_NOT_S:  w_single = {1'b0, ~s};
            ALU_NEG_S:  w_single = {(WIDTH+1){1'b0}} - w_s_ext;
            default:    w_single = w_s_ext;
        endcase
    end

    alu_seq_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (w_accept & w_multi),
        .op     (alu_op),
        .a      (w_iter_a),
        .b      (s),
        .cnt    (w_shift_k),
        .done   (w_iter_done),
        .result (w_iter_result),
        .carry  (w_iter_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept && w_multi) w_state_next = BUSY;
            BUSY:    if (w_iter_done)         w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Output register loads either a single-cycle result at accept or the
    // engine result on its final step; these never coincide because the
    // block cannot accept while BUSY.
    assign w_load  = (w_accept & ~w_multi) | ((r_state == BUSY) & w_iter_done);
    assign w_res_y = (r_state == BUSY) ? w_iter_result : w_single[WIDTH-1:0];
    assign w_res_c = (r_state == BUSY) ? w_iter_carry  : w_single[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y         <= '0;
            r_c         <= 1'b0;
            r_n         <= 1'b0;
            r_z         <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_y         <= w_res_y;
            r_c         <= w_res_c;
            r_n         <= w_res_y[WIDTH-1];
            r_z         <= (w_res_y == '0);
            r_out_valid <= 1'b1;
        end else if (w_accept || (r_out_valid && out_ready)) begin
            // Either the result was consumed, or an engine op just started
            // (which can only be accepted once any old result is consumed).
            r_out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Directed self-checking bench for alu_seq (WIDTH=16).
//                Follows ALU_MUL_EN for the opcode 1101 expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_op;
    logic [15:0] r;
    logic [15:0] s;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] y;
    logic        n;
    logic        z;
    logic        c;
    logic        busy;

    int checks;
    int errors;

    alu_seq #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .r         (r),
        .s         (s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .n         (n),
        .z         (z),
        .c         (c),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present an op and advance past one edge; in_valid is left high.
    task automatic send(input logic [3:0] op, input logic [15:0] rv, input logic [15:0] sv);
        in_valid = 1'b1;
        alu_op   = op;
        r        = rv;
        s        = sv;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Edges elapsed after the accept edge until out_valid, bounded at 40.
    task automatic wait_result(output int edges);
        edges = 0;
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, y, n, z, c, in_ready, busy} !== {1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got v=%b y=%h nzc=%b%b%b rdy=%b busy=%b want v=0 y=0000 nzc=010 rdy=1 busy=0",
                     out_valid, y, n, z, c, in_ready, busy);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        send(ALU_ADD, 16'hFFFF, 16'h0001);
        checks++;
        if ({out_valid, y, n, z, c} !== {1'b1, 16'h0000, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL add_wrap got v=%b y=%h nzc=%b%b%b want v=1 y=0000 nzc=011", out_valid, y, n, z, c);
        end
        send(ALU_SUB, 16'h0003, 16'h0005);
        checks++;
        if ({out_valid, y, n, z, c} !== {1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL sub_borrow got v=%b y=%h nzc=%b%b%b want v=1 y=fffe nzc=101", out_valid, y, n, z, c);
        end
        idle_cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_drop got v=%b want v=0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  t_op [14] = '{ALU_PASS_S, ALU_PASS_R, ALU_INC_S, ALU_DEC_S, ALU_SHR1, ALU_SHL1, ALU_AND,
                                   ALU_OR, ALU_XOR, ALU_NOT_S, ALU_NEG_S, ALU_NEG_S, ALU_SUB, ALU_ADD};
        logic [15:0] t_r  [14] = '{16'h0000, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hF0F0,
                                   16'hF0F0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0005, 16'h8000};
        logic [15:0] t_s  [14] = '{16'h8001, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0003, 16'h8001, 16'hFF00,
                                   16'h0F00, 16'hFFFF, 16'h00FF, 16'h0001, 16'h0000, 16'h0003, 16'h8000};
        logic [15:0] t_y  [14] = '{16'h8001, 16'h1234, 16'h0000, 16'hFFFF, 16'h0001, 16'h0002, 16'hF000,
                                   16'hFFF0, 16'h0000, 16'hFF00, 16'hFFFF, 16'h0000, 16'h0002, 16'h0000};
        logic        t_c  [14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                                   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [15:0] ey;
        for (int i = 0; i < 14; i++) begin
            send(t_op[i], t_r[i], t_s[i]);
            ey = t_y[i];
            checks++;
            if ({out_valid, y, n, z, c} !== {1'b1, ey, ey[15], (ey == 16'h0000), t_c[i]}) begin
                errors++;
                $display("FAIL b2b_%0d op=%b got v=%b y=%h nzc=%b%b%b want y=%h c=%b",
                         i, t_op[i], out_valid, y, n, z, c, ey, t_c[i]);
            end
        end
        idle_cycle();
    endtask

    task automatic test_shift();
        int edges;
        send(ALU_SHL_N, 16'h0004, 16'h9000);
        in_valid = 1'b0;
        checks++;
        if ({busy, in_ready, out_valid} !== 3'b100) begin
            errors++;
            $display("FAIL shl_busy got busy=%b rdy=%b v=%b want 1 0 0", busy, in_ready, out_valid);
        end
        wait_result(edges);
        checks++;
        if (!out_valid || edges != 4) begin
            errors++;
            $display("FAIL shl_latency got v=%b edges=%0d want v=1 edges=4", out_valid, edges);
        end
        checks++;
        if ({y, n, z, c, busy} !== {16'h0000, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL shl_result got y=%h nzc=%b%b%b busy=%b want y=0000 nzc=011 busy=0", y, n, z, c, busy);
        end
        idle_cycle();

        // Only R[3:0] is the distance: FFF1 shifts by 1.
        send(ALU_SHR_N, 16'hFFF1, 16'h0031);
        in_valid = 1'b0;
        wait_result(edges);
        checks++;
        if ({out_valid, y, n, z, c} !== {1'b1, 16'h0018, 1'b0, 1'b0, 1'b1} || edges != 1) begin
            errors++;
            $display("FAIL shr_k1 got v=%b y=%h nzc=%b%b%b edges=%0d want y=0018 nzc=001 edges=1",
                     out_valid, y, n, z, c, edges);
        end
        idle_cycle();

        send(ALU_SHR_N, 16'h0000, 16'h1234);
        checks++;
        if ({busy, out_valid, y, n, z, c} !== {1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL shr_k0 got busy=%b v=%b y=%h nzc=%b%b%b want busy=0 v=1 y=1234 nzc=000",
                     busy, out_valid, y, n, z, c);
        end
        idle_cycle();
    endtask

    task automatic test_mul();
        int edges;
`ifdef ALU_MUL_EN
        send(ALU_MUL, 16'h0100, 16'h0100);
        in_valid = 1'b0;
        checks++;
        if ({busy, in_ready} !== 2'b10) begin
            errors++;
            $display("FAIL mul_busy got busy=%b rdy=%b want 1 0", busy, in_ready);
        end
        wait_result(edges);
        checks++;
        if ({out_valid, y, n, z, c} !== {1'b1, 16'h0000, 1'b0, 1'b1, 1'b1} || edges != 16) begin
            errors++;
            $display("FAIL mul_overflow got v=%b y=%h nzc=%b%b%b edges=%0d want y=0000 nzc=011 edges=16",
                     out_valid, y, n, z, c, edges);
        end
        idle_cycle();
        send(ALU_MUL, 16'h00FF, 16'h0003);
        in_valid = 1'b0;
        wait_result(edges);
        checks++;
        if ({out_valid, y, n, z, c} !== {1'b1, 16'h02FD, 1'b0, 1'b0, 1'b0} || edges != 16) begin
            errors++;
            $display("FAIL mul_small got v=%b y=%h nzc=%b%b%b edges=%0d want y=02fd nzc=000 edges=16",
                     out_valid, y, n, z, c, edges);
        end
        idle_cycle();
`else
        send(ALU_MUL, 16'h0100, 16'h0100);
        checks++;
        if ({busy, out_valid, y, n, z, c} !== {1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mul_off_pass got busy=%b v=%b y=%h nzc=%b%b%b want busy=0 v=1 y=0100 nzc=000",
                     busy, out_valid, y, n, z, c);
        end
        send(ALU_MUL, 16'h1234, 16'h8000);
        checks++;
        if ({busy, out_valid, y, n, z, c} !== {1'b0, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mul_off_pass_s got busy=%b v=%b y=%h nzc=%b%b%b want busy=0 v=1 y=8000 nzc=100",
                     busy, out_valid, y, n, z, c);
        end
        idle_cycle();
`endif
        edges = 0;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(ALU_ADD, 16'h0002, 16'h0003);
        alu_op = ALU_SUB;
        r      = 16'h0009;
        s      = 16'h0001;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, y, n, z, c, in_ready} !== {1'b1, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL hold_%0d got v=%b y=%h nzc=%b%b%b rdy=%b want v=1 y=0005 nzc=000 rdy=0",
                         i, out_valid, y, n, z, c, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL drain_ready got rdy=%b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, y, n, z, c} !== {1'b1, 16'h0008, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL drain_accept got v=%b y=%h nzc=%b%b%b want v=1 y=0008 nzc=000", out_valid, y, n, z, c);
        end
        idle_cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_drop got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_mid_reset();
        logic seen;
        send(ALU_ADD, 16'h0001, 16'h0001);
`ifdef ALU_MUL_EN
        send(ALU_MUL, 16'h1234, 16'h5678);
`else
        send(ALU_SHL_N, 16'h000F, 16'hFFFF);
`endif
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if ({busy, out_valid, y} !== {1'b1, 1'b0, 16'h0002}) begin
            errors++;
            $display("FAIL pre_reset got busy=%b v=%b y=%h want busy=1 v=0 y=0002", busy, out_valid, y);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, y, n, z, c, busy, in_ready} !== {1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL async_reset got v=%b y=%h nzc=%b%b%b busy=%b rdy=%b want v=0 y=0000 nzc=010 busy=0 rdy=1",
                     out_valid, y, n, z, c, busy, in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL aborted_op got activity=%b want 0", seen);
        end
        send(ALU_ADD, 16'h0001, 16'h0001);
        checks++;
        if ({out_valid, y, n, z, c} !== {1'b1, 16'h0002, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL post_reset_add got v=%b y=%h nzc=%b%b%b want v=1 y=0002 nzc=000", out_valid, y, n, z, c);
        end
        idle_cycle();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        alu_op    = 4'h0;
        r         = 16'h0000;
        s         = 16'h0000;
        out_ready = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_shift();
        test_mul();
        test_backpressure();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
